vga_pattern_writer: RTL and testbench

VGA_PATTERN_WRITER -- requirements
Module: vga_pattern_writer

---
 rtl/vga_mem_pkg.sv | 25 ++
 rtl/pattern_counter.sv | 62 ++++++
 rtl/vga_pattern_writer.sv | 131 +++++++++++++
 tb/tb_vga_pattern_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared definitions for the SDRAM frame-buffer path: the writer FSM
// encoding and the default frame geometry used by the writer, the
// arbiter and the VGA reader.
package vga_mem_pkg;

  localparam int DEF_WIDTH      = 1024;
  localparam int DEF_DATA_DEPTH = DEF_WIDTH * 240;
  localparam int DEF_MEM_UNIT   = DEF_WIDTH * 1024;
  localparam int DEF_ADDR_W     = 24;
  localparam int PIXEL_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } wr_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_counter.sv
// Pattern sequencing for one frame: word counter, wrapping column counter
// and the per-frame offset. The column counter is preloaded from the
// offset at frame start, so word i of a frame carries (i + offset) mod
// WIDTH without any divider.
module pattern_counter
  import vga_mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int COL_W      = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,  // preload column, clear word count
  input  logic             word_xfer,    // one pixel word accepted
  input  logic             frame_end,    // frame committed, advance offset
  output logic [COL_W-1:0] col,
  output logic             last_word
);

  localparam int WORD_W = cnt_width(DATA_DEPTH);

  logic [COL_W-1:0]  offset_reg;
  logic [COL_W-1:0]  col_reg;
  logic [WORD_W-1:0] word_reg;

  logic [COL_W-1:0]  col_next;
  logic [COL_W-1:0]  offset_next;

  // Wrap-around increments for the column and offset counters.
  always_comb begin
    col_next    = (col_reg == COL_W'(WIDTH - 1)) ? '0 : col_reg + COL_W'(1);
    offset_next = (offset_reg == COL_W'(WIDTH - 1)) ? '0 : offset_reg + COL_W'(1);
  end

  // Column and word counters: restart at frame start, step on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg  <= '0;
      word_reg <= '0;
    end else if (frame_start) begin
      col_reg  <= offset_reg;
      word_reg <= '0;
    end else if (word_xfer) begin
      col_reg  <= col_next;
      word_reg <= word_reg + WORD_W'(1);
    end
  end

  // Offset shifts the pattern by one column for every committed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_reg <= '0;
    end else if (frame_end) begin
      offset_reg <= offset_next;
    end
  end

  assign col       = col_reg;
  assign last_word = (word_reg == WORD_W'(DATA_DEPTH - 1));

endmodule

// File: rtl/vga_pattern_writer.sv
// Test-pattern frame writer. Streams DATA_DEPTH pixel words per frame into
// the SDRAM arbiter's write FIFO, alternating between two frame buffers,
// and announces each frame once the arbiter reports it committed.
module vga_pattern_writer
  import vga_mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int MEM_UNIT   = DEF_MEM_UNIT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               mem_wr_load,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic               wr_valid,
  output logic [PIXEL_W-1:0] wr_data,
  input  logic               wr_ready,
  input  logic               mem_wr_done,
  output logic               frame_ready,
  output logic               ready_buf,
  output logic               err
);

  localparam int COL_W = cnt_width(WIDTH);

  wr_state_t        state_reg;
  wr_state_t        state_next;
  logic             cur_buf_reg;
  logic             ready_buf_reg;
  logic             err_reg;

  logic             frame_start;
  logic             word_xfer;
  logic             frame_end;
  logic [COL_W-1:0] col;
  logic             last_word;

  pattern_counter #(
    .WIDTH      (WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .COL_W      (COL_W)
  ) u_pattern_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .word_xfer   (word_xfer),
    .frame_end   (frame_end),
    .col         (col),
    .last_word   (last_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-state strobes; enable is only consulted in IDLE so
  // a frame in flight always runs to completion.
  always_comb begin
    state_next  = state_reg;
    mem_wr_load = 1'b0;
    wr_valid    = 1'b0;
    frame_ready = 1'b0;
    frame_start = 1'b0;
    word_xfer   = 1'b0;
    frame_end   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        mem_wr_load = 1'b1;
        frame_start = 1'b1;
        state_next  = ST_STREAM;
      end
      ST_STREAM: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          word_xfer = 1'b1;
          if (last_word) state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (mem_wr_done) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        frame_ready = 1'b1;
        frame_end   = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Buffer ping-pong: the committed buffer is published, the other one
  // becomes the target of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_buf_reg   <= 1'b0;
      ready_buf_reg <= 1'b0;
    end else if (frame_end) begin
      ready_buf_reg <= cur_buf_reg;
      cur_buf_reg   <= ~cur_buf_reg;
    end
  end

  // Sticky error: a done pulse outside WAIT_DONE is a protocol violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (mem_wr_done && (state_reg != ST_WAIT_DONE)) begin
      err_reg <= 1'b1;
    end
  end

  // cur_buf only changes on leaving FINISH, so the base address is stable
  // for the whole LOAD..FINISH span without a separate register.
  assign mem_wr_addr = cur_buf_reg ? ADDR_W'(MEM_UNIT) : '0;
  assign wr_data     = PIXEL_W'(col);
  assign ready_buf   = ready_buf_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_vga_pattern_writer.sv
// Self-checking bench for vga_pattern_writer with an 8-pixel, 24-word frame.
// Expected values come from the frame rule: frame L lives in buffer L mod 2
// and word i carries (i + L) mod WIDTH.
module tb_vga_pattern_writer;

  localparam int WIDTH      = 8;
  localparam int DATA_DEPTH = 24;
  localparam int MEM_UNIT   = 64;
  localparam int ADDR_W     = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              mem_wr_load;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              wr_valid;
  logic [15:0]       wr_data;
  logic              wr_ready;
  logic              mem_wr_done;
  logic              frame_ready;
  logic              ready_buf;
  logic              err;

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_no = 0;

  vga_pattern_writer #(
    .WIDTH      (WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .MEM_UNIT   (MEM_UNIT),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mem_wr_load (mem_wr_load),
    .mem_wr_addr (mem_wr_addr),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_wr_done (mem_wr_done),
    .frame_ready (frame_ready),
    .ready_buf   (ready_buf),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int idx);
    return 32'((idx + frame_no) % WIDTH);
  endfunction

  function automatic logic [31:0] exp_addr();
    return 32'((frame_no % 2) * MEM_UNIT);
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_load"},  32'(mem_wr_load), 32'd0);
    chk({tag, "_valid"}, 32'(wr_valid),    32'd0);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_data"},  32'(wr_data),     32'd0);
    chk({tag, "_addr"},  32'(mem_wr_addr), 32'd0);
    chk({tag, "_rbuf"},  32'(ready_buf),   32'd0);
    chk({tag, "_err"},   32'(err),         32'd0);
  endtask

  // One frame from LOAD to the committed-frame pulse.
  // rdy_mode: 0 always ready, 1 one-on/two-off, 2 random.
  // Negative drop_en_at / spur_at / rst_at disable that event.
  task automatic run_frame(input int rdy_mode, input int done_wait, input int drop_en_at,
                           input int spur_at, input int rst_at, input int exp_gap,
                           input bit chk_lat);
    int  gap;
    int  idx;
    int  k;
    int  t_load;
    int  waited;
    bit  seen;
    bit  rdy;
    seen = 1'b0;
    gap  = 0;
    while (!seen && gap < 8) begin
      @(negedge clk);
      gap++;
      if (mem_wr_load === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk("load_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_gap > 0) chk("load_gap", 32'(gap), 32'(exp_gap));
    chk("load_addr", 32'(mem_wr_addr), exp_addr());
    chk("load_valid", 32'(wr_valid), 32'd0);
    t_load   = cyc;
    wr_ready = 1'($urandom_range(0, 1));

    idx    = 0;
    k      = 0;
    waited = 0;
    while (idx < DATA_DEPTH && waited < 300) begin
      @(negedge clk);
      waited++;
      mem_wr_done = 1'b0;
      if (rst_at >= 0 && idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        return;
      end
      chk("stream_valid", 32'(wr_valid), 32'd1);
      chk("stream_data", 32'(wr_data), exp_word(idx));
      chk("addr_stable", 32'(mem_wr_addr), exp_addr());
      if (drop_en_at >= 0 && idx == drop_en_at) enable = 1'b0;
      if (spur_at >= 0 && idx == spur_at) mem_wr_done = 1'b1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      k++;
      wr_ready = rdy;
      if (rdy) idx++;
    end
    if (idx < DATA_DEPTH) begin
      chk("stream_timeout", 32'(idx), 32'(DATA_DEPTH));
      return;
    end

    @(negedge clk);
    mem_wr_done = 1'b0;
    chk("valid_after_last", 32'(wr_valid), 32'd0);
    wr_ready = 1'($urandom_range(0, 1));
    for (int w = 0; w < done_wait; w++) begin
      chk("no_early_ready", 32'(frame_ready), 32'd0);
      @(negedge clk);
      wr_ready = 1'($urandom_range(0, 1));
      chk("wait_valid", 32'(wr_valid), 32'd0);
    end
    mem_wr_done = 1'b1;
    @(negedge clk);
    mem_wr_done = 1'b0;
    chk("frame_ready", 32'(frame_ready), 32'd1);
    chk("finish_addr", 32'(mem_wr_addr), exp_addr());
    if (chk_lat) chk("latency", 32'(cyc - t_load + 1), 32'(DATA_DEPTH + 3));
    @(posedge clk);
    #1;
    chk("ready_pulse_len", 32'(frame_ready), 32'd0);
    chk("ready_buf", 32'(ready_buf), 32'(frame_no % 2));
    $display("[TB] frame %0d done: buf=%0d words=%0d", frame_no, frame_no % 2, idx);
    frame_no++;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    wr_ready    = 1'b0;
    mem_wr_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_load", 32'(mem_wr_load), 32'd0);
    enable = 1'b1;

    // Back-to-back frames with ideal handshake.
    run_frame(0, 0, -1, -1, -1, 0, 1'b1);
    run_frame(0, 0, -1, -1, -1, 2, 1'b1);
    run_frame(0, 0, -1, -1, -1, 2, 1'b1);

    // Stalled and randomized handshakes, randomized done delay.
    run_frame(1, 0, -1, -1, -1, 2, 1'b0);
    for (int r = 0; r < 3; r++) run_frame(2, int'($urandom_range(0, 3)), -1, -1, -1, 2, 1'b0);
    chk("err_clean", 32'(err), 32'd0);

    // Spurious done during streaming flags err; frame still completes.
    run_frame(0, 0, -1, 5, -1, 2, 1'b1);
    chk("err_set", 32'(err), 32'd1);

    // Enable dropped mid-frame: frame completes, then no further LOAD.
    run_frame(0, 0, 10, -1, -1, 2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stay_idle", 32'(mem_wr_load | wr_valid), 32'd0);
    end
    chk("err_sticky", 32'(err), 32'd1);

    // Full reset clears err and restarts the buffer/offset sequence.
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst2");
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    enable   = 1'b1;
    frame_no = 0;
    run_frame(0, 0, -1, -1, -1, 0, 1'b1);
    run_frame(0, 0, -1, -1, 12, 2, 1'b0);
    repeat (2) @(negedge clk);
    chk_reset_outs("rst_hold");
    rst_n    = 1'b1;
    frame_no = 0;
    run_frame(0, 0, -1, -1, -1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
